// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word fall-through FIFO of ALU results with stored zero/msb flags.
// Defining ALU_RES_STATS_EN adds a saturating drop_cnt of pushes refused while full.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 64,
  parameter int SEL_W = 3
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ACC_W-1:0]         Acc,
  input  logic [SEL_W-1:0]         sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_acc,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_zero,
  output logic                     out_msb,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
`ifdef ALU_RES_STATS_EN
  output logic [15:0]              drop_cnt,
`endif
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ACC_W + SEL_W + 2;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign empty     = count == '0;
  assign full      = count == CW'(DEPTH);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {Acc, sel, Acc == '0, Acc[ACC_W-1]};
  end
  assign {out_acc, out_sel, out_zero, out_msb} = empty ? '0 : mem[rd_ptr];
`ifdef ALU_RES_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else if (in_valid && !in_ready && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: scoreboard bench; a monitor checks every presented head against expected queue.
module tb_alu_result_fifo;
  typedef struct packed {
    logic [63:0] acc;
    logic [2:0]  sel;
    logic        z;
    logic        m;
  } ent_t;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, out_zero, out_msb, full, empty;
  logic [63:0] Acc = '0, out_acc;
  logic [2:0]  sel = '0, out_sel;
  logic [2:0]  count;
`ifdef ALU_RES_STATS_EN
  logic [15:0] drop_cnt;
`endif
  ent_t q[$];
  int tests = 0, fails = 0;
  alu_result_fifo dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Acc(Acc), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_sel(out_sel), .out_zero(out_zero), .out_msb(out_msb),
    .count(count), .full(full),
`ifdef ALU_RES_STATS_EN
    .drop_cnt(drop_cnt),
`endif
    .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          chk("out_acc", out_acc, q[0].acc);
          chk("out_sel", 64'(out_sel), 64'(q[0].sel));
          chk("out_zero", 64'(out_zero), 64'(q[0].z));
          chk("out_msb", 64'(out_msb), 64'(q[0].m));
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        chk("idle_outs_zero", {out_acc[59:0], out_sel, out_zero | out_msb}, 64'd0);
        chk("idle_sb_empty", 64'(q.size()), 64'd0);
      end
    end
  end
  task automatic push(input logic [63:0] a, input logic [2:0] s, input logic z, input logic m);
    int n = 0;
    in_valid = 1; Acc = a; sel = s;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 20) begin chk("push_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    q.push_back('{acc: a, sel: s, z: z, m: m});
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("drain_done", 64'(q.size()), 64'd0);
    out_ready = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_acc", out_acc, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    // single pass
    push(64'd327, 3'd0, 1'b0, 1'b0);
    in_valid = 0;
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    chk("t2_out_acc", out_acc, 64'd327);
    chk("t2_count", 64'(count), 64'd1);
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    chk("t2_empty", 64'(empty), 64'd1);
    // fill and overflow
    for (int i = 1; i <= 4; i++) push(64'(i), 3'(i), 1'b0, 1'b0);
    in_valid = 0;
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    chk("t3_count", 64'(count), 64'd4);
    fork
      push(64'd5, 3'd5, 1'b0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1;
        @(posedge clk); #1 out_ready = 0;
      end
    join
    in_valid = 0;
    chk("t3_count_after", 64'(count), 64'd4);
`ifdef ALU_RES_STATS_EN
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd3);
`endif
    drain();
    // flags
    out_ready = 0;
    push(64'd0, 3'd0, 1'b1, 1'b0);
    push(64'hFFFF_FFFF_FFFF_FF81, 3'd1, 1'b0, 1'b1);
    in_valid = 0;
    drain();
    // wrap with concurrent push/pop
    out_ready = 1;
    for (int i = 10; i < 20; i++) begin
      push(64'(i), 3'(i % 8), 1'b0, 1'b0);
      chk("t5_count", 64'(count), 64'd1);
    end
    in_valid = 0;
    drain();
    // mid-operation reset
    for (int i = 0; i < 3; i++) push(64'(100 + i), 3'(i), 1'b0, 1'b0);
    in_valid = 0;
    chk("t6_count_pre", 64'(count), 64'd3);
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_out_acc", out_acc, 64'd0);
    chk("t6_empty", 64'(empty), 64'd1);
    q.delete();
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    #1 chk("t6_empty_after", 64'(empty), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 32-bit ALU (P, Q, 3-bit sel, 64-bit Acc).
- Captures each ALU result together with the sel code that produced it into a small synchronous FIFO.
- Presents entries to the consumer over a valid/ready handshake, with per-entry zero and sign flags.
- Decouples the combinational ALU from a consumer that may stall.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- ACC_W, 64, result width; matches the ALU Acc output.
- SEL_W, 3, width of the op-select tag stored with each entry.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  Acc/sel hold a result to capture.
- in_ready  output  1  FIFO can accept this cycle.
- Acc  input  ACC_W  ALU result.
- sel  input  SEL_W  op code that produced Acc.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head entry.
- out_acc  output  ACC_W  head entry result.
- out_sel  output  SEL_W  head entry op code.
- out_zero  output  1  head result == 0.
- out_msb  output  1  head result bit ACC_W-1.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst_n low, asynchronous): rd/wr pointers = 0, count = 0, empty = 1, full = 0, out_valid = 0.
  - out_acc, out_sel, out_zero and out_msb read 0.
  - Storage contents are don't-care.
  - Reset asserted mid-transfer discards all entries; no partial pop or push survives.
- in_ready = !full, combinational from registered state only; it does not depend on out_ready.
- Push: on the clk edge where in_valid && in_ready.
  - Store {Acc, sel, Acc==0, Acc[ACC_W-1]} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
  - Zero/msb flags are computed at push time and stored.
- Pop: on the clk edge where out_valid && out_ready; rd_ptr increments modulo DEPTH.
- First-word fall-through:
  - out_valid = !empty.
  - out_* driven from the entry at rd_ptr.
  - All out_* are forced to 0 when empty.
- Latency: a push at edge N makes out_valid = 1 after edge N, with the data visible in cycle N+1. There is no same-cycle bypass from Acc to out_acc.
- Stall: while out_valid && !out_ready, out_acc/out_sel/out_zero/out_msb hold stable.
- Simultaneous push and pop when 0 < count < DEPTH: both occur and count is unchanged.
- Push when full: not accepted (in_ready = 0). A pop in the same cycle does not enable the push; it is accepted next cycle.
- Pop when empty: ignored (out_valid = 0).
- Pointer wrap: DEPTH-1 -> 0; ordering is strictly FIFO across wrap.
- count, full and empty update on the same edge as the push/pop.

Optional Feature:
- Macro: ALU_RES_STATS_EN.
- Defined:
  - Adds output drop_cnt [15:0].
  - drop_cnt increments on every edge where in_valid && !in_ready, saturating at 16'hFFFF.
  - Reset to 0 by rst_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset then idle: rst_n low for 2 cycles, then release -> empty = 1, count = 0, out_valid = 0, out_acc = 0, in_ready = 1.
2. Single pass:
   - Stimulus: push Acc = 64'd327, sel = 3'd0 with out_ready = 0.
   - Next cycle: out_valid = 1, out_acc = 327, out_sel = 0, out_zero = 0, out_msb = 0, count = 1.
   - Assert out_ready for one cycle -> empty = 1.
3. Fill and overflow:
   - Stimulus: push 5 results Acc = 1..5 with out_ready = 0.
   - After 4 pushes: full = 1, in_ready = 0, count = 4.
   - The 5th push is held off until space exists.
   - With ALU_RES_STATS_EN, drop_cnt = 1 per stalled cycle.
4. Flags: push Acc = 0, then Acc = 64'hFFFF_FFFF_FFFF_FF81 (sel = 3'd1) -> first entry out_zero = 1, out_msb = 0; second entry out_zero = 0, out_msb = 1.
5. Wrap with concurrent push/pop:
   - Stimulus: out_ready = 1 constantly, in_valid = 1 for 10 cycles with Acc = 10..19, sel cycling 0..7.
   - Outputs appear in order 10..19 with matching sel; count stays 1 in steady state; pointers wrap twice.
6. Reset mid-operation: with count = 3, pulse rst_n low asynchronously between edges -> outputs immediately read 0, count = 0, no stale entry appears after release.
